instr_fetch: RTL and testbench
==============================

// Module: instr_fetch
// PURPOSE
//  Fetch stage, directly upstream of the decode stage. Owns the PC, issues one-word reads to
//  instruction memory over a req/gnt + rvalid handshake and presents {instr, pc, instr_valid}
//  to decode. Decode redirects via redirect_valid/redirect_pc (jumps, taken branches); stall holds output.
// PARAMETERS
//  RESET_PC   32'h0000_0000  first fetch address after reset release
//  MAX_OUTST  2              max outstanding imem requests (1..3); sets skid-buffer depth
// PORTS
//  clk            in   1   single clock, rising edge
//  reset          in   1   asynchronous, active-low reset (0 = in reset)
//  imem_req       out  1   read request; held with imem_addr until imem_gnt
//  imem_addr      out  32  word-aligned fetch address
//  imem_gnt       in   1   request accepted this cycle
//  imem_rvalid    in   1   response data valid; responses return in request order, >=1 cycle after gnt
//  imem_rdata     in   32  response instruction word
//  stall          in   1   decode cannot accept; instr/pc/instr_valid frozen
//  redirect_valid in   1   flush + restart at redirect_pc (one-cycle pulse)
//  redirect_pc    in   32  new PC
//  instr          out  32  instruction to decode (NOP 32'h0000_0013 when not valid)
//  pc             out  32  address of instr
//  instr_valid    out  1   instr/pc hold a real fetched instruction
//  fetch_fault    out  1   misaligned redirect target (only with IFETCH_ALIGN_CHECK_EN)
// BEHAVIOUR
//  - Reset (async assert, sync release): imem_req=0, imem_addr=RESET_PC, instr=NOP, pc=RESET_PC,
//    instr_valid=0, fetch_fault=0, outstanding count=0, drop count=0, buffer empty, state=BOOT.
//  - FSM: BOOT -> RUN on first cycle after release. RUN: imem_req=1 while outstanding+buffered
//    < MAX_OUTST; on req&gnt, imem_addr += 4 next cycle (wraps 32'hFFFF_FFFC -> 0).
//  - Responses enter a FIFO (depth MAX_OUTST) with their PC; head drives decode outputs registered.
//    Best-case latency: gnt at cycle N, rvalid at N+1 -> instr_valid at N+2.
//  - stall=1: outputs hold; responses keep filling FIFO; no new req if it would overflow.
//    FIFO never overflows: requests are only issued when space is reserved.
//  - stall=0, FIFO empty: instr_valid=0, instr=NOP next cycle (bubble).
//  - redirect_valid=1: next cycle imem_addr=redirect_pc, FIFO cleared, instr_valid=0,
//    drop count = outstanding un-returned requests; those rvalids are discarded. A req held but
//    not granted is withdrawn (address replaced). Redirect wins over stall and over a same-cycle rvalid.
//  - Back-to-back redirects: each reloads the drop count with total outstanding; no stale word leaks.
//  - imem_rvalid with zero outstanding: ignored (protocol error, assertion in sim).
//  - Reset mid-transaction: all counters cleared; late rvalid after release is ignored by rule above.
// CONFIGURATION
//  IFETCH_ALIGN_CHECK_EN defined: redirect_pc[1:0]!=0 -> no fetch issued, FSM to FAULT,
//    fetch_fault=1, instr_valid=0, held until next aligned redirect or reset.
//  Undefined: redirect_pc[1:0] forced to 2'b00, fetch_fault tied 0, no FAULT state.
// STRUCTURE
//  Shared package mriscv_pkg: NOP_INSTR constant, opcode localparams (OP_R, OP_I, OP_LOAD,
//    OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC), fetch FSM state encoding.
//  One sub-module: ifetch_skid_buf (parameterised-depth FIFO of {pc,instr}, push/pop/flush, full/empty).
// TESTING
//  1 Release reset, imem 1-cycle, no stall -> addrs 0,4,8..; instr_valid first high 2 cycles after
//    first gnt; pc sequence 0,4,8 matches rdata.
//  2 stall=1 for 5 cycles with 0x00500093 at output -> instr/pc unchanged, imem_req drops after
//    MAX_OUTST words held; release -> all buffered words delivered in order, none lost.
//  3 redirect to 0x100 with 2 requests outstanding -> both responses dropped, next instr_valid
//    has pc=0x100.
//  4 redirect and imem_rvalid same cycle, then second redirect next cycle -> only target-2 words emerge.
//  5 imem_gnt low 3 cycles -> imem_req/imem_addr stable throughout; fetch address 0xFFFF_FFFC wraps to 0.
//  6 IFETCH_ALIGN_CHECK_EN: redirect 0x102 -> fetch_fault=1, no imem_req; redirect 0x200 clears it;
//    without macro -> fetches 0x100. Assert reset mid-wait -> all outputs at reset values asynchronously.

Source files
------------

// File: rtl/mriscv_pkg.sv
`default_nettype none
//============================================================================
// Module      : mriscv_pkg
// Description : Shared constants for the mriscv core. Holds the canonical
//               NOP encoding, the base opcode map, the fetch-stage state
//               encoding and a small address helper.
// Revision    : 1.0  initial release
//============================================================================
package mriscv_pkg;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } fetch_state_e;

    // Sequential word address; wraps 32'hFFFF_FFFC -> 0 by natural overflow.
    function automatic logic [31:0] next_word_addr(input logic [31:0] a);
        return a + 32'd4;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ifetch_skid_buf.sv
`default_nettype none
//============================================================================
// Module      : ifetch_skid_buf
// Description : Small circular FIFO holding {pc, instr} pairs for responses
//               that decode could not take yet. Supports simultaneous
//               push/pop and a synchronous flush that empties it.
// Ports       : clk, rst_n (async active-low), push_i/din_i, pop_i/dout_o,
//               flush_i, full_o, empty_o, count_o
// Revision    : 1.0  initial release
//============================================================================
module ifetch_skid_buf #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           push_i,
    input  logic [WIDTH-1:0]               din_i,
    input  logic                           pop_i,
    input  logic                           flush_i,
    output logic [WIDTH-1:0]               dout_o,
    output logic                           full_o,
    output logic                           empty_o,
    output logic [$clog2(DEPTH+1)-1:0]     count_o
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_q, rd_q;
    logic [CW-1:0]    cnt_q;
    logic             w_do_push, w_do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign w_do_pop  = pop_i && (cnt_q != '0);
    // A push into a full buffer is allowed only when a pop frees a slot.
    assign w_do_push = push_i && ((cnt_q != CW'(DEPTH)) || w_do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (flush_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (w_do_push) begin
                mem_q[wr_q] <= din_i;
                wr_q        <= ptr_inc(wr_q);
            end
            if (w_do_pop) rd_q <= ptr_inc(rd_q);
            cnt_q <= cnt_q + CW'(w_do_push) - CW'(w_do_pop);
        end
    end

    assign dout_o  = mem_q[rd_q];
    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;

endmodule
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
//============================================================================
// Module      : instr_fetch
// Description : Fetch stage. Owns the PC, issues one-word reads over a
//               req/gnt + rvalid handshake, buffers returned words with their
//               PC and presents {instr, pc, instr_valid} to decode. Decode
//               redirects with redirect_valid/redirect_pc; stall freezes the
//               decode-facing outputs.
// Ports       : clk, reset (async active-low)
//               imem_req/imem_addr (out), imem_gnt/imem_rvalid/imem_rdata (in)
//               stall, redirect_valid, redirect_pc (in)
//               instr, pc, instr_valid, fetch_fault (out)
// Config      : IFETCH_ALIGN_CHECK_EN - misaligned redirect parks the stage
//               in FAULT with fetch_fault=1 instead of aligning the target.
// Revision    : 1.0  initial release
//============================================================================
module instr_fetch
    import mriscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          MAX_OUTST = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] instr,
    output logic [31:0] pc,
    output logic        instr_valid,
    output logic        fetch_fault
);
    localparam int CW = $clog2(MAX_OUTST + 1);
    localparam int SW = CW + 1;

    fetch_state_e  state_q, state_d;
    logic          req_q;
    logic [31:0]   addr_q;
    logic [31:0]   rsp_pc_q;      // PC of the next live response
    logic [CW-1:0] outst_q;       // granted, not yet returned (live + doomed)
    logic [CW-1:0] drop_q;        // oldest outstanding responses to discard
    logic [31:0]   instr_q, pc_q;
    logic          valid_q;

    logic          w_fire, w_rv_acc, w_rv_live;
    logic          w_pop, w_bypass, w_push, w_space, w_misaligned;
    logic [CW-1:0] w_outst_nxt, w_fifo_cnt, w_fifo_cnt_nxt;
    logic [31:0]   w_target;
    logic [63:0]   w_head;
    logic          w_fifo_empty, w_fifo_full;

`ifdef IFETCH_ALIGN_CHECK_EN
    logic fault_q;
    assign w_target     = redirect_pc;
    assign w_misaligned = redirect_valid && (redirect_pc[1:0] != 2'b00);
    assign fetch_fault  = fault_q;
`else
    assign w_target     = redirect_pc & 32'hFFFF_FFFC;
    assign w_misaligned = 1'b0;
    assign fetch_fault  = 1'b0;
`endif

    assign w_fire    = req_q && imem_gnt;
    // An rvalid with nothing outstanding is a protocol error and is ignored.
    assign w_rv_acc  = imem_rvalid && (outst_q != '0);
    // Redirect kills a same-cycle response as well as the doomed ones.
    assign w_rv_live = w_rv_acc && (drop_q == '0) && !redirect_valid;

    assign w_pop    = !redirect_valid && !stall && !w_fifo_empty;
    // Empty buffer: a live response goes straight to the output register so
    // the best-case gnt -> instr_valid latency is two cycles.
    assign w_bypass = !redirect_valid && !stall && w_fifo_empty && w_rv_live;
    assign w_push   = w_rv_live && !w_bypass;

    assign w_outst_nxt    = outst_q + CW'(w_fire) - CW'(w_rv_acc);
    assign w_fifo_cnt_nxt = redirect_valid ? '0
                          : w_fifo_cnt + CW'(w_push) - CW'(w_pop);
    // Doomed responses still count so the buffer can never overflow.
    assign w_space = (SW'(w_outst_nxt) + SW'(w_fifo_cnt_nxt)) < SW'(MAX_OUTST);

    always_comb begin
        state_d = state_q;
        if (redirect_valid)            state_d = w_misaligned ? ST_FAULT : ST_RUN;
        else if (state_q == ST_BOOT)   state_d = ST_RUN;
    end

    ifetch_skid_buf #(
        .DEPTH (MAX_OUTST),
        .WIDTH (64)
    ) u_skid (
        .clk     (clk),
        .rst_n   (reset),
        .push_i  (w_push),
        .din_i   ({rsp_pc_q, imem_rdata}),
        .pop_i   (w_pop),
        .flush_i (redirect_valid),
        .dout_o  (w_head),
        .full_o  (w_fifo_full),
        .empty_o (w_fifo_empty),
        .count_o (w_fifo_cnt)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_BOOT;
            req_q    <= 1'b0;
            addr_q   <= RESET_PC;
            rsp_pc_q <= RESET_PC;
            outst_q  <= '0;
            drop_q   <= '0;
            instr_q  <= NOP_INSTR;
            pc_q     <= RESET_PC;
            valid_q  <= 1'b0;
`ifdef IFETCH_ALIGN_CHECK_EN
            fault_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            // Next-state counts are used, so an ungranted request stays up
            // (its sum can only shrink) and a redirect re-evaluates it.
            req_q   <= (state_d == ST_RUN) && w_space;

            if (redirect_valid && !w_misaligned) addr_q <= w_target;
            else if (w_fire)                     addr_q <= next_word_addr(addr_q);

            outst_q <= w_outst_nxt;
            if (redirect_valid)                     drop_q <= w_outst_nxt;
            else if (w_rv_acc && (drop_q != '0))    drop_q <= drop_q - CW'(1);

            if (redirect_valid)  rsp_pc_q <= w_target;
            else if (w_rv_live)  rsp_pc_q <= next_word_addr(rsp_pc_q);

            if (redirect_valid) begin
                valid_q <= 1'b0;
                instr_q <= NOP_INSTR;
            end else if (!stall) begin
                if (!w_fifo_empty) begin
                    pc_q    <= w_head[63:32];
                    instr_q <= w_head[31:0];
                    valid_q <= 1'b1;
                end else if (w_rv_live) begin
                    pc_q    <= rsp_pc_q;
                    instr_q <= imem_rdata;
                    valid_q <= 1'b1;
                end else begin
                    valid_q <= 1'b0;
                    instr_q <= NOP_INSTR;
                end
            end

`ifdef IFETCH_ALIGN_CHECK_EN
            if (redirect_valid) fault_q <= w_misaligned;
`endif
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = addr_q;
    assign instr       = instr_q;
    assign pc          = pc_q;
    assign instr_valid = valid_q;

`ifndef SYNTHESIS
    a_rvalid_no_outst: assert property (@(posedge clk) disable iff (!reset)
        !(imem_rvalid && (outst_q == '0)))
        else $error("imem_rvalid with no outstanding request");
    a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
        !(w_push && w_fifo_full && !w_pop))
        else $error("skid buffer push while full");
`endif

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
//============================================================================
// Module      : tb_instr_fetch
// Description : Directed bench for instr_fetch with an in-order, fixed
//               latency instruction memory model.
// Revision    : 1.0  initial release
//============================================================================
module tb_instr_fetch;
    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req, imem_gnt, imem_rvalid;
    logic [31:0] imem_addr, imem_rdata;
    logic        stall, redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] instr, pc;
    logic        instr_valid, fetch_fault;

    logic        gnt_en;
    int          lat;
    int          n_pass, n_total;
    logic        pv [4];
    logic [31:0] pa [4];
    logic [31:0] fire_q[$], dpc_q[$], dins_q[$];

    always #5 clk = ~clk;

    instr_fetch #(.RESET_PC(32'h0), .MAX_OUTST(2)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .instr(instr), .pc(pc), .instr_valid(instr_valid), .fetch_fault(fetch_fault)
    );

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        if (a == 32'h0000_0010) return 32'h0050_0093;
        return a ^ 32'h5A00_0000;
    endfunction

    // Memory: response exactly lat cycles after the grant, in order.
    assign imem_gnt    = gnt_en;
    assign imem_rvalid = pv[0];
    assign imem_rdata  = mem_data(pa[0]);
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) begin pv[i] <= 1'b0; pa[i] <= 32'h0; end
        end else begin
            for (int i = 0; i < 3; i++) begin pv[i] <= pv[i+1]; pa[i] <= pa[i+1]; end
            pv[3] <= 1'b0;
            if (imem_req && imem_gnt) begin pv[lat-1] <= 1'b1; pa[lat-1] <= imem_addr; end
        end
    end

    function automatic int pend();
        return int'(pv[0]) + int'(pv[1]) + int'(pv[2]) + int'(pv[3]);
    endfunction
    function automatic logic [31:0] fire_at(input int k);
        return (fire_q.size() > k) ? fire_q[k] : 32'hDEAD_BEEF;
    endfunction
    function automatic logic [31:0] dpc_at(input int k);
        return (dpc_q.size() > k) ? dpc_q[k] : 32'hDEAD_BEEF;
    endfunction
    function automatic logic [31:0] dins_at(input int k);
        return (dins_q.size() > k) ? dins_q[k] : 32'hDEAD_BEEF;
    endfunction

    // Record what happened in the current cycle, then advance one cycle.
    task automatic step();
        if (imem_req && imem_gnt) fire_q.push_back(imem_addr);
        if (instr_valid && !stall) begin dpc_q.push_back(pc); dins_q.push_back(instr); end
        @(posedge clk); #1;
    endtask

    task automatic clear_q();
        fire_q.delete(); dpc_q.delete(); dins_q.delete();
    endtask

    task automatic redirect(input logic [31:0] target);
        redirect_valid = 1'b1; redirect_pc = target;
        step();
        redirect_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_total++; if (imem_req !== 1'b0) $display("FAIL reset_req got %0b want 0", imem_req); else n_pass++;
        n_total++; if (imem_addr !== 32'h0) $display("FAIL reset_addr got %h want 0", imem_addr); else n_pass++;
        n_total++; if (instr !== 32'h13) $display("FAIL reset_instr got %h want 00000013", instr); else n_pass++;
        n_total++; if (pc !== 32'h0) $display("FAIL reset_pc got %h want 0", pc); else n_pass++;
        n_total++; if (instr_valid !== 1'b0) $display("FAIL reset_valid got %0b want 0", instr_valid); else n_pass++;
        n_total++; if (fetch_fault !== 1'b0) $display("FAIL reset_fault got %0b want 0", fetch_fault); else n_pass++;
        reset = 1'b1;
    endtask

    task automatic test_fetch();
        int first_gnt = -1, first_val = -1;
        clear_q();
        for (int i = 0; i < 10; i++) begin
            if (first_gnt < 0 && imem_req && imem_gnt) first_gnt = i;
            if (first_val < 0 && instr_valid) first_val = i;
            step();
        end
        n_total++; if (first_gnt !== 1) $display("FAIL first_gnt_cycle got %0d want 1", first_gnt); else n_pass++;
        n_total++; if (first_val - first_gnt !== 2) $display("FAIL gnt_to_valid got %0d want 2", first_val - first_gnt); else n_pass++;
        for (int k = 0; k < 4; k++) begin
            n_total++;
            if (fire_at(k) !== 32'(4 * k)) $display("FAIL fetch_addr[%0d] got %h want %h", k, fire_at(k), 32'(4 * k));
            else n_pass++;
        end
        for (int k = 0; k < 3; k++) begin
            n_total++;
            if (dpc_at(k) !== 32'(4 * k) || dins_at(k) !== mem_data(32'(4 * k)))
                $display("FAIL fetch_out[%0d] got pc=%h instr=%h want pc=%h instr=%h",
                         k, dpc_at(k), dins_at(k), 32'(4 * k), mem_data(32'(4 * k)));
            else n_pass++;
        end
    endtask

    task automatic test_stall();
        logic found = 1'b0;
        logic [31:0] exp_pc;
        redirect(32'h10);
        for (int i = 0; i < 20 && !found; i++) begin
            if (instr_valid && pc == 32'h10) found = 1'b1; else step();
        end
        n_total++; if (found !== 1'b1) $display("FAIL stall_reach_0x10 got %0b want 1", found); else n_pass++;
        clear_q();
        stall = 1'b1;
        for (int s = 0; s < 5; s++) begin
            n_total++;
            if (instr_valid !== 1'b1 || pc !== 32'h10 || instr !== 32'h0050_0093)
                $display("FAIL stall_hold[%0d] got v=%0b pc=%h instr=%h want v=1 pc=00000010 instr=00500093",
                         s, instr_valid, pc, instr);
            else n_pass++;
            if (s >= 2) begin
                n_total++; if (imem_req !== 1'b0) $display("FAIL stall_req[%0d] got %0b want 0", s, imem_req); else n_pass++;
            end
            step();
        end
        stall = 1'b0;
        repeat (6) step();
        for (int k = 0; k < 4; k++) begin
            exp_pc = 32'h10 + 32'(4 * k);
            n_total++;
            if (dpc_at(k) !== exp_pc || dins_at(k) !== mem_data(exp_pc))
                $display("FAIL stall_drain[%0d] got pc=%h instr=%h want pc=%h instr=%h",
                         k, dpc_at(k), dins_at(k), exp_pc, mem_data(exp_pc));
            else n_pass++;
        end
    endtask

    task automatic test_redirect();
        logic found = 1'b0;
        lat = 2;
        for (int i = 0; i < 30 && !found; i++) begin
            if (pend() == 2) found = 1'b1; else step();
        end
        n_total++; if (found !== 1'b1) $display("FAIL redir_two_outst got %0b want 1", found); else n_pass++;
        redirect(32'h100);
        clear_q();
        n_total++; if (imem_addr !== 32'h100) $display("FAIL redir_addr got %h want 00000100", imem_addr); else n_pass++;
        n_total++; if (instr_valid !== 1'b0 || instr !== 32'h13) $display("FAIL redir_bubble got v=%0b instr=%h want v=0 instr=00000013", instr_valid, instr); else n_pass++;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (instr_valid) found = 1'b1; else step();
        end
        n_total++; if (dpc_q.size() !== 0) $display("FAIL redir_leak got %0d words want 0", dpc_q.size()); else n_pass++;
        n_total++;
        if (found !== 1'b1 || pc !== 32'h100 || instr !== mem_data(32'h100))
            $display("FAIL redir_first got v=%0b pc=%h instr=%h want v=1 pc=00000100 instr=%h", found, pc, instr, mem_data(32'h100));
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic found = 1'b0;
        int stale = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (imem_rvalid) found = 1'b1; else step();
        end
        n_total++; if (found !== 1'b1) $display("FAIL b2b_rvalid_seen got %0b want 1", found); else n_pass++;
        redirect(32'h300);
        redirect(32'h400);
        clear_q();
        repeat (15) step();
        foreach (dpc_q[k]) if (dpc_q[k] < 32'h400) stale++;
        n_total++; if (stale !== 0) $display("FAIL b2b_stale got %0d want 0", stale); else n_pass++;
        n_total++;
        if (dpc_at(0) !== 32'h400 || dins_at(0) !== mem_data(32'h400))
            $display("FAIL b2b_first got pc=%h instr=%h want pc=00000400 instr=%h", dpc_at(0), dins_at(0), mem_data(32'h400));
        else n_pass++;
        n_total++; if (dpc_at(1) !== 32'h404) $display("FAIL b2b_second got pc=%h want 00000404", dpc_at(1)); else n_pass++;
    endtask

    task automatic test_gnt_wrap();
        logic found = 1'b0;
        logic [31:0] exp_a [3];
        exp_a[0] = 32'hFFFF_FFF8; exp_a[1] = 32'hFFFF_FFFC; exp_a[2] = 32'h0000_0000;
        gnt_en = 1'b0;
        redirect(32'hFFFF_FFF8);
        for (int i = 0; i < 10 && !found; i++) begin
            if (imem_req) found = 1'b1; else step();
        end
        n_total++;
        if (found !== 1'b1 || imem_addr !== 32'hFFFF_FFF8) $display("FAIL wait_req got req=%0b addr=%h want req=1 addr=fffffff8", found, imem_addr);
        else n_pass++;
        for (int s = 0; s < 3; s++) begin
            step();
            n_total++;
            if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFF8)
                $display("FAIL gnt_hold[%0d] got req=%0b addr=%h want req=1 addr=fffffff8", s, imem_req, imem_addr);
            else n_pass++;
        end
        gnt_en = 1'b1;
        clear_q();
        repeat (10) step();
        for (int k = 0; k < 3; k++) begin
            n_total++;
            if (fire_at(k) !== exp_a[k] || dpc_at(k) !== exp_a[k] || dins_at(k) !== mem_data(exp_a[k]))
                $display("FAIL wrap[%0d] got addr=%h pc=%h instr=%h want %h/%h/%h",
                         k, fire_at(k), dpc_at(k), dins_at(k), exp_a[k], exp_a[k], mem_data(exp_a[k]));
            else n_pass++;
        end
    endtask

    task automatic test_align_and_reset();
        logic found = 1'b0;
        logic any_req = 1'b0;
`ifdef IFETCH_ALIGN_CHECK_EN
        redirect(32'h102);
        n_total++; if (fetch_fault !== 1'b1 || instr_valid !== 1'b0) $display("FAIL align_fault got f=%0b v=%0b want f=1 v=0", fetch_fault, instr_valid); else n_pass++;
        for (int i = 0; i < 6; i++) begin any_req = any_req | imem_req; step(); end
        n_total++; if (any_req !== 1'b0) $display("FAIL align_no_req got %0b want 0", any_req); else n_pass++;
        redirect(32'h200);
        n_total++; if (fetch_fault !== 1'b0) $display("FAIL align_clear got %0b want 0", fetch_fault); else n_pass++;
        for (int i = 0; i < 20 && !found; i++) begin
            if (instr_valid) found = 1'b1; else step();
        end
        n_total++; if (found !== 1'b1 || pc !== 32'h200) $display("FAIL align_resume got v=%0b pc=%h want v=1 pc=00000200", found, pc); else n_pass++;
`else
        redirect(32'h102);
        n_total++; if (imem_addr !== 32'h100 || fetch_fault !== 1'b0) $display("FAIL align_force got addr=%h f=%0b want addr=00000100 f=0", imem_addr, fetch_fault); else n_pass++;
        for (int i = 0; i < 20 && !found; i++) begin
            if (instr_valid) found = 1'b1; else step();
        end
        n_total++;
        if (found !== 1'b1 || pc !== 32'h100 || instr !== mem_data(32'h100))
            $display("FAIL align_fetch got v=%0b pc=%h instr=%h want v=1 pc=00000100 instr=%h", found, pc, instr, mem_data(32'h100));
        else n_pass++;
`endif
        // Reset in the middle of a grant wait, away from any clock edge.
        gnt_en = 1'b0;
        repeat (3) step();
        any_req = imem_req;
        #3 reset = 1'b0;
        #1;
        n_total++;
        if (imem_req !== 1'b0 || imem_addr !== 32'h0 || instr !== 32'h13 || pc !== 32'h0 ||
            instr_valid !== 1'b0 || fetch_fault !== 1'b0 || any_req !== 1'b1)
            $display("FAIL async_reset got req=%0b addr=%h instr=%h pc=%h v=%0b f=%0b pending=%0b want 0/0/00000013/0/0/0/1",
                     imem_req, imem_addr, instr, pc, instr_valid, fetch_fault, any_req);
        else n_pass++;
        @(posedge clk); #1;
        reset = 1'b1; gnt_en = 1'b1;
        clear_q();
        repeat (8) step();
        n_total++;
        if (fire_at(0) !== 32'h0 || dpc_at(0) !== 32'h0 || dins_at(0) !== mem_data(32'h0))
            $display("FAIL post_reset got addr=%h pc=%h instr=%h want 0/0/%h", fire_at(0), dpc_at(0), dins_at(0), mem_data(32'h0));
        else n_pass++;
    endtask

    initial begin
        n_pass = 0; n_total = 0;
        reset = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        gnt_en = 1'b1; lat = 1;
        test_reset();
        test_fetch();
        test_stall();
        test_redirect();
        test_back_to_back();
        test_gnt_wrap();
        test_align_and_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running want finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
